emailbox_tx: RTL

Mailbox transmitter: the sending end of the emesh mailbox protocol. Software writes a 64-bit message and a destination mailbox address through the register interface. The block queues each message in a small internal FIFO. It then emits one emesh 64-bit write packet per message toward the remote receiving mailbox, honouring the fabric/mailbox `wait` pushback. It sits between the local register bus and the emesh transmit port.

---
 rtl/emailbox_tx.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/emailbox_tx.sv
// Mailbox transmitter: queues software-written 64-bit messages and emits one emesh write packet each.
// Latency: TXLO write at edge N -> emesh_access high after edge N+1 (empty queue, wait low); 1 packet/cycle.
// Backpressure: emesh_wait freezes the output stage and the FIFO; TXLO writes into a full FIFO are dropped
// and set sticky overflow.
// Ports: clk/reset (sync, active-high); reg_access/reg_packet/reg_rdata register bus;
//        emesh_access/emesh_packet/emesh_wait transmit port; tx_irq_en/tx_irq interrupt.
module emailbox_tx #(
   parameter int AW    = 32,
   parameter int PW    = 2*AW+40,
   parameter int RFAW  = 6,
   parameter int DEPTH = 16,
   parameter int CW    = $clog2(DEPTH)
)(
   input  logic          clk,
   input  logic          reset,
   input  logic          reg_access,
   input  logic [PW-1:0] reg_packet,
   output logic [31:0]   reg_rdata,
   output logic          emesh_access,
   output logic [PW-1:0] emesh_packet,
   input  logic          emesh_wait,
   input  logic          tx_irq_en,
   output logic          tx_irq
);

   localparam int EW = 3*AW;   // FIFO entry: {dst, hi, lo}

   // register bus field extraction
   logic            reg_write;
   logic [AW-1:0]   reg_dstaddr;
   logic [AW-1:0]   reg_data;
   logic [RFAW-1:0] reg_idx;

   assign reg_write   = reg_packet[0];
   assign reg_dstaddr = reg_packet[AW+7:8];
   assign reg_data    = reg_packet[2*AW+7:AW+8];
   assign reg_idx     = reg_dstaddr[RFAW+1:2];

   logic unused_reg_bits;
   assign unused_reg_bits = ^{reg_packet[7:1], reg_packet[PW-1:2*AW+8],
                              reg_dstaddr[AW-1:RFAW+2], reg_dstaddr[1:0]};

   logic wr_lo, wr_hi, wr_dst, wr_stat, rd;
   assign wr_lo   = reg_access &  reg_write & (reg_idx == RFAW'(0));
   assign wr_hi   = reg_access &  reg_write & (reg_idx == RFAW'(1));
   assign wr_dst  = reg_access &  reg_write & (reg_idx == RFAW'(2));
   assign wr_stat = reg_access &  reg_write & (reg_idx == RFAW'(3));
   assign rd      = reg_access & ~reg_write;

   // state
   logic [AW-1:0] hi_reg, dst_reg;
   logic          overflow;
   logic [EW-1:0] mem [DEPTH];
   logic [CW-1:0] wr_ptr, rd_ptr;
   logic [CW:0]   count;

   logic empty, full, push, pop, load, pending;
   logic [EW-1:0] head;

   assign empty   = (count == '0);
   assign full    = (count == (CW+1)'(DEPTH));
   // full is judged before any same-cycle pop, so a write racing a pop is still dropped
   assign push    = wr_lo & ~full;
   assign load    = ~emesh_access | ~emesh_wait;
   assign pop     = load & ~empty;
   assign head    = mem[rd_ptr];
   assign pending = ~empty | emesh_access;
   assign tx_irq  = tx_irq_en & (~pending | overflow);

   logic [31:0] status;
   assign status = {8'(count), 20'd0, emesh_access, overflow, full, pending};

   // outgoing packet built from the FIFO head: write, datamode=3, ctrlmode=0
   logic [PW-1:0] next_pkt;
   always_comb begin
      next_pkt                 = '0;
      next_pkt[0]              = 1'b1;
      next_pkt[2:1]            = 2'b11;
      next_pkt[AW+7:8]         = head[3*AW-1:2*AW];
      next_pkt[2*AW+7:AW+8]    = head[AW-1:0];
      next_pkt[PW-1:2*AW+8]    = (PW-2*AW-8)'(head[2*AW-1:AW]);
   end

   logic [31:0] rd_mux;
   always_comb begin
      rd_mux = '0;
      case (reg_idx)
         RFAW'(1): rd_mux = 32'(hi_reg);
         RFAW'(2): rd_mux = 32'(dst_reg);
         RFAW'(3): rd_mux = status;
         default:  rd_mux = '0;
      endcase
   end

   // FIFO storage needs no reset; occupancy is tracked by count
   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr] <= {dst_reg, hi_reg, reg_data};
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         hi_reg       <= '0;
         dst_reg      <= '0;
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         count        <= '0;
         overflow     <= 1'b0;
         emesh_access <= 1'b0;
         emesh_packet <= '0;
         reg_rdata    <= '0;
      end else begin
         if (wr_hi)  hi_reg  <= reg_data;
         if (wr_dst) dst_reg <= reg_data;

         if (push) wr_ptr <= wr_ptr + CW'(1);
         if (pop)  rd_ptr <= rd_ptr + CW'(1);

         case ({push, pop})
            2'b10:   count <= count + (CW+1)'(1);
            2'b01:   count <= count - (CW+1)'(1);
            default: count <= count;
         endcase

         if (wr_lo & full)
            overflow <= 1'b1;
         else if (wr_stat & reg_data[2])
            overflow <= 1'b0;

         // stage reloads whenever it is empty or its packet is being consumed
         if (load) begin
            emesh_access <= ~empty;
            if (~empty)
               emesh_packet <= next_pkt;
         end

         reg_rdata <= rd ? rd_mux : 32'd0;
      end
   end

endmodule
